// File: rtl/apb_rr_master_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_rr_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_AW = 32;
  localparam int APB_DW = 8;

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NREQ requests, search starting
// just after the last winner. The pointer moves only on an enabled grant.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]     ptr_q;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                off;
  int                sum;

  // Rotating a doubled vector puts requester (ptr+1) mod NREQ at bit 0;
  // a pointer increment that wraps past NREQ-1 still lands on the right slot.
  always_comb begin
    dbl   = {req_i, req_i};
    rot   = NREQ'(dbl >> (ptr_q + 1'b1));
    any_o = |req_i;
    off   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr_q) + 1 + off;
    if (sum >= NREQ) sum = sum - NREQ;
    grant_idx_o = IW'(sum);
    grant_o     = any_o ? (NREQ'(1) << grant_idx_o) : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (en_i && any_o) begin
      ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ local requesters: round-robin grant, SETUP/ACCESS
// sequencing with PREADY wait and timeout abort, one-hot response to the owner.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic               PSELx,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PWDATA,
  input  logic [DW-1:0]      PRDATA,
  input  logic               PREADY
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  apb_state_t    state_q;
  logic          pend_q;
  logic [IW-1:0] owner_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  logic [NREQ-1:0] req_ready_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [NREQ-1:0] owner_mask;
  logic [NREQ-1:0] arb_req;
  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  // The current owner cannot win again until its response has gone out.
  assign owner_mask = (state_q == IDLE) ? '0 : (NREQ'(1) << owner_q);
  assign arb_req    = req_valid & ~owner_mask;
  assign arb_en     = ((state_q == IDLE) && !pend_q) || ((state_q == ACCESS) && PREADY);
  assign timer_d    = timer_q + 1'b1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_i       (arb_req),
    .en_i        (arb_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      owner_q     <= '0;
      timer_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A grant from IDLE spends one cycle with only req_ready asserted.
          if (pend_q) begin
            pend_q  <= 1'b0;
            state_q <= SETUP;
            psel_q  <= 1'b1;
          end else if (grant_any) begin
            pend_q      <= 1'b1;
            req_ready_q <= grant;
            owner_q     <= grant_idx;
            pwrite_q    <= req_write[grant_idx];
            paddr_q     <= addr_arr[grant_idx];
            pwdata_q    <= wdata_arr[grant_idx];
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          timer_q   <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q <= NREQ'(1) << owner_q;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            penable_q   <= 1'b0;
            if (grant_any) begin
              state_q     <= SETUP;
              req_ready_q <= grant;
              owner_q     <= grant_idx;
              pwrite_q    <= req_write[grant_idx];
              paddr_q     <= addr_arr[grant_idx];
              pwdata_q    <= wdata_arr[grant_idx];
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_valid_q <= NREQ'(1) << owner_q;
            rsp_err_q   <= 1'b1;
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = psel_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: requester queues, APB slave model and a
// transaction-level scoreboard with a round-robin reference.
module tb_apb_rr_master;

  localparam int NREQ = 4, AW = 32, DW = 8, TIMEOUT = 16;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_n;
    logic [DW-1:0] prdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_acc;
  } vec_t;

  logic               PCLK, PRESETn;
  logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, PWDATA, PRDATA;
  logic               rsp_err, busy, PSELx, PENABLE, PWRITE, PREADY;
  logic [AW-1:0]      PADDR;

  apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int vectors = 0, miscompares = 0;

  cmd_t cmdq [NREQ][$];
  int   grants[$];
  int   last_grant = NREQ - 1, cyc = 0, grant_cyc = 0, acc_cnt = 0;
  int   rsp_count = 0, b2b_count = 0;
  bit   cur_valid = 0, cur_b2b = 0, prev_setup = 0;
  int   cur_id = 0;
  cmd_t cur;
  int   last_rsp_id = -1, last_rsp_acc = 0;
  logic last_rsp_err = 0;
  logic [DW-1:0] last_rsp_rdata = '0;

  // Slave behaviour: mode 0 uses fixed per-test settings, mode 1 derives from address.
  bit            slave_mode = 0;
  int            wait_v = 0;
  logic [DW-1:0] prdata_v = '0;

  int            mon_w, mon_ew, mon_owner;
  bit            mon_rsp, mon_e;
  logic [NREQ-1:0] mon_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int slave_wait(input logic [AW-1:0] a);
    if (!slave_mode) return wait_v;
    return (a[5:2] == 4'hF) ? 20 : int'(a[1:0]);
  endfunction

  function automatic logic [DW-1:0] slave_rdata(input logic [AW-1:0] a);
    if (!slave_mode) return prdata_v;
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (cmdq[i].size() != 0) return 0;
    return 1;
  endfunction

  // Scoreboard, requester driver and slave, all evaluated on the falling edge.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      cur_valid  = 0;
      last_grant = NREQ - 1;
      acc_cnt    = 0;
      prev_setup = 0;
    end else begin
      chk("busy_vs_psel", busy, PSELx);
      if (prev_setup) chk("penable_after_setup", PENABLE, 1'b1);
      mon_rsp   = |rsp_valid;
      mon_owner = -1;
      if (mon_rsp) begin
        rsp_count++;
        if (!cur_valid) chk("rsp_spurious", rsp_valid, '0);
        else begin
          mon_e = (slave_wait(cur.addr) >= TIMEOUT);
          chk("rsp_onehot", rsp_valid, NREQ'(1) << cur_id);
          chk("rsp_err", rsp_err, mon_e);
          chk("rsp_rdata", rsp_rdata, (mon_e || cur.wr) ? '0 : slave_rdata(cur.addr));
          chk("access_cycles", acc_cnt, mon_e ? TIMEOUT : slave_wait(cur.addr) + 1);
          last_rsp_id = cur_id; last_rsp_err = rsp_err;
          last_rsp_rdata = rsp_rdata; last_rsp_acc = acc_cnt;
          mon_owner = cur_id;
          cur_valid = 0;
        end
      end
      if (|req_ready) begin
        mon_mask = (mon_owner >= 0) ? (NREQ'(1) << mon_owner) : '0;
        mon_ew   = rr_pick(req_valid & ~mon_mask, last_grant);
        mon_w    = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_w = i;
        chk("grant_onehot", $countones(req_ready), 1);
        chk("grant_winner", mon_w, mon_ew);
        if (mon_rsp) begin
          chk("grant_after_abort", rsp_err, 1'b0);
          b2b_count++;
        end
        if (mon_w >= 0 && cmdq[mon_w].size() > 0) begin
          cur = cmdq[mon_w][0]; cur_id = mon_w; cur_valid = 1;
          cur_b2b = mon_rsp; grant_cyc = cyc;
          grants.push_back(mon_w); last_grant = mon_w;
        end else chk("grant_without_req", req_ready, '0);
      end
      prev_setup = PSELx && !PENABLE;
      if (PSELx && !PENABLE) begin
        if (!cur_valid) chk("setup_without_grant", PSELx, 1'b0);
        else begin
          chk("setup_latency", cyc - grant_cyc, cur_b2b ? 0 : 1);
          chk("paddr", PADDR, cur.addr);
          chk("pwrite", PWRITE, cur.wr);
          chk("pwdata", PWDATA, cur.wdata);
        end
        acc_cnt = 0;
      end
      if (PSELx && PENABLE) begin
        acc_cnt++;
        if (cur_valid) chk("paddr_stable", PADDR, cur.addr);
      end
      cyc++;
    end
    for (int i = 0; i < NREQ; i++)
      if (PRESETn && req_ready[i] && cmdq[i].size() > 0) void'(cmdq[i].pop_front());
    for (int i = 0; i < NREQ; i++) begin
      if (cmdq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_write[i] = cmdq[i][0].wr;
        req_addr[i*AW +: AW]  = cmdq[i][0].addr;
        req_wdata[i*DW +: DW] = cmdq[i][0].wdata;
      end else begin
        req_valid[i] = 1'b0;
        req_write[i] = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_wdata[i*DW +: DW] = '0;
      end
    end
    if (PRESETn && PSELx && PENABLE && acc_cnt > slave_wait(PADDR)) begin
      PREADY = 1'b1; PRDATA = slave_rdata(PADDR);
    end else begin
      PREADY = 1'b0; PRDATA = 8'hEE;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge PCLK); #1;
      if (queues_empty() && !cur_valid && !PSELx && req_ready == '0) done = 1;
    end
    chk({"idle_", name}, done, 1'b1);
  endtask

  task automatic push(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d;
    cmdq[id].push_back(c);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) cmdq[i].delete();
  endtask

  vec_t tbl[7];
  int   g0, rc0, b0;
  int   exp_order[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run still active, required finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESETn = 1'b0;
    tbl[0] = '{0, 1'b1, 32'h10,       8'hA5, 0,  8'hFF, 1'b0, 8'h00, 1};
    tbl[1] = '{2, 1'b0, 32'h10,       8'h00, 2,  8'h3C, 1'b0, 8'h3C, 3};
    tbl[2] = '{1, 1'b0, 32'h20,       8'h00, 40, 8'h77, 1'b1, 8'h00, 16};
    tbl[3] = '{3, 1'b1, 32'hDEADBEEF, 8'h5A, 15, 8'h99, 1'b0, 8'h00, 16};
    tbl[4] = '{1, 1'b0, 32'h44,       8'h00, 14, 8'h81, 1'b0, 8'h81, 15};
    tbl[5] = '{0, 1'b0, 32'h0,        8'h00, 16, 8'h42, 1'b1, 8'h00, 16};
    tbl[6] = '{2, 1'b0, 32'hFFFFFFFF, 8'h00, 1,  8'h00, 1'b0, 8'h00, 2};

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, PSELx, PENABLE,
                          PWRITE, PADDR, PWDATA}, '0);
    @(negedge PCLK); #2; PRESETn = 1'b1;

    // Single transfers with hand-computed expectations
    for (int v = 0; v < 7; v++) begin
      @(posedge PCLK);
      wait_v = tbl[v].wait_n; prdata_v = tbl[v].prdata; rc0 = rsp_count;
      push(tbl[v].id, tbl[v].wr, tbl[v].addr, tbl[v].wdata);
      wait_idle(200, "table");
      chk("tbl_rsp_count", rsp_count - rc0, 1);
      chk("tbl_rsp_id", last_rsp_id, tbl[v].id);
      chk("tbl_rsp_err", last_rsp_err, tbl[v].exp_err);
      chk("tbl_rsp_rdata", last_rsp_rdata, tbl[v].exp_rdata);
      chk("tbl_access_cycles", last_rsp_acc, tbl[v].exp_acc);
    end

    // All four requesters valid out of reset: 0,1,2,3 back-to-back
    wait_v = 0; prdata_v = 8'h5C;
    @(posedge PCLK); #2; PRESETn = 1'b0;
    @(posedge PCLK); clear_queues();
    g0 = grants.size(); b0 = b2b_count;
    for (int i = 0; i < NREQ; i++) push(i, i[0], 32'h100 + i, 8'(i));
    @(negedge PCLK); #2; PRESETn = 1'b1;
    wait_idle(200, "all4");
    for (int i = 0; i < NREQ; i++) chk("all4_order", grants[g0 + i], i);
    chk("all4_b2b", b2b_count - b0, NREQ - 1);

    // Requester 1 holds continuously, requester 3 joins: no starvation
    @(posedge PCLK);
    g0 = grants.size();
    for (int i = 0; i < 3; i++) push(1, 1'b0, 32'h200 + i, 8'h00);
    @(posedge PCLK);
    for (int i = 0; i < 2; i++) push(3, 1'b1, 32'h300 + i, 8'h30 + 8'(i));
    wait_idle(300, "alternate");
    exp_order = '{1, 3, 1, 3, 1};
    for (int i = 0; i < 5; i++) chk("alternate_order", grants[g0 + i], exp_order[i]);

    // Reset in the middle of ACCESS
    wait_v = 40;
    @(posedge PCLK);
    push(2, 1'b0, 32'h400, 8'h00);
    b0 = 0;
    for (int c = 0; c < 20 && !b0; c++) begin
      @(negedge PCLK);
      if (PSELx && PENABLE) b0 = 1;
    end
    chk("reach_access", b0, 1);
    repeat (3) @(posedge PCLK);
    #2; PRESETn = 1'b0; #1;
    chk("async_reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, PSELx, PENABLE,
                                PWRITE, PADDR, PWDATA}, '0);
    rc0 = rsp_count;
    @(posedge PCLK); clear_queues(); wait_v = 0;
    repeat (2) @(posedge PCLK);
    chk("no_rsp_in_reset", rsp_count - rc0, 0);
    g0 = grants.size();
    for (int i = NREQ - 1; i >= 0; i--) push(i, 1'b1, 32'h500 + i, 8'h50);
    @(negedge PCLK); #2; PRESETn = 1'b1;
    wait_idle(200, "post_reset");
    chk("post_reset_first_grant", grants[g0], 0);
    chk("post_reset_rsp_count", rsp_count - rc0, NREQ);

    // Randomised traffic against the scoreboard
    slave_mode = 1;
    rc0 = rsp_count;
    b0 = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge PCLK);
      if ($urandom_range(0, 3) == 0) begin
        push($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
        b0++;
      end
    end
    wait_idle(20000, "random");
    chk("random_rsp_count", rsp_count - rc0, b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
